uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Next-generation UART transmitter. It adds an on-chip baud-rate divider and a small input FIFO, so back-to-back writes are not lost. Parity enable, parity type and stop-bit count are selectable per frame at runtime. It sits between the parallel-data producer and the serial line, in place of the fixed-configuration transmitter.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9).
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- P_DATA_from_input  in  DATA_WIDTH  parallel word to transmit.
- DATA_VALID  in  1  write strobe; one word per cycle high.
- par_en  in  1  1 = append parity bit.
- par_type  in  1  0 = even parity, 1 = odd parity.
- two_stop  in  1  1 = two stop bits, 0 = one stop bit.
- tx_out  out  1  serial line, idle high, registered.
- busy_flag  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- data_lost  out  1  one-cycle pulse when a write is dropped because the FIFO is full.
- frame_done  out  1  one-cycle pulse in the last cycle of the final stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset (async, immediate): tx_out=1, busy_flag=0, data_lost=0, frame_done=0, fifo_count=0. FIFO pointers cleared, FSM=IDLE, baud counter=0. Reset mid-frame aborts the frame; tx_out is high on the reset assertion itself.
- FIFO write: at the rising edge where DATA_VALID=1 and fifo_count<FIFO_DEPTH, the word is stored.
  - If fifo_count==FIFO_DEPTH, the word is dropped and data_lost=1 in the next cycle.
  - Fullness is evaluated before the same-cycle pop, so a write while full is dropped even if a pop happens in that cycle.
- FIFO read: the FSM pops in IDLE when fifo_count>0.
  - At the pop edge it latches the data word, par_en, par_type and two_stop.
  - It also computes parity: the even bit is the XOR of all data bits; the odd bit is its inverse.
  - Changes to the config inputs mid-frame have no effect on the current frame.
- FSM states, each bit lasting exactly CLKS_PER_BIT cycles (baud counter 0..CLKS_PER_BIT-1; it resets on every state entry):
  - IDLE: tx_out=1. Pop -> START.
  - START: tx_out=0 -> DATA.
  - DATA: LSB first; the bit index counts 0..DATA_WIDTH-1. After the last bit: -> PARITY if par_en, else -> STOP1.
  - PARITY: tx_out = parity bit -> STOP1.
  - STOP1: tx_out=1. -> STOP2 if two_stop, else end of frame.
  - STOP2: tx_out=1 -> end of frame.
  - End of frame: frame_done pulses in the final cycle of the last stop bit.
    - If fifo_count>0 at that edge, the FSM pops and goes directly to START (no idle gap).
    - Otherwise it goes to IDLE.
- Latency: a write into an empty FIFO with FSM in IDLE at edge N is popped at edge N+1; tx_out falls after edge N+2.
- Frame length is (1 + DATA_WIDTH + par_en + 1 + two_stop) * CLKS_PER_BIT cycles.
- busy_flag and fifo_count are registered. fifo_count updates on the edge after the push or pop; a simultaneous push and pop when not full leaves it unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by the extra count bit.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum: IDLE, START, DATA, PARITY, STOP1, STOP2;
  - parity type constants PAR_EVEN=0 and PAR_ODD=1;
  - a width helper for counters.
- One sub-module: uart_sync_fifo, a parametrised DATA_WIDTH x FIFO_DEPTH synchronous FIFO with push, pop, full, empty and count.
- The baud counter and FSM stay in the top module.

Test Plan:
- Frame 0xA5, 8N1, CLKS_PER_BIT=4, par_en=0, two_stop=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles). frame_done pulses once. busy_flag falls on the edge after frame_done.
- Frame 0xA5 with par_en=1 -> parity bit is 0 when par_type=0 and 1 when par_type=1. Frame length is 44 cycles. Toggling par_type mid-frame does not change the transmitted bit.
- Frame 0x3C with two_stop=1, par_en=1, par_type=0 -> parity 0 followed by two stop bits. Frame length is 48 cycles.
- Four consecutive-cycle writes 0x01..0x04 with FIFO_DEPTH=4 -> all four frames are sent back-to-back with no idle cycles. data_lost stays 0.
- Write 0x11..0x16 on consecutive cycles (FIFO_DEPTH=4, FSM idle) -> 0x11 is popped, 0x12..0x15 fill the FIFO, and 0x16 is dropped. data_lost pulses one cycle, and exactly five frames are sent.
- Assert rst during DATA bit 3 -> tx_out=1, busy_flag=0, fifo_count=0 immediately. After release, a new write of 0x55 produces a correct full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is ignored, pop while empty is ignored.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  // NOTE: storage carries no reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, baud divider and per-frame parity/stop configuration.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       P_DATA_from_input,
  input  logic                        DATA_VALID,
  input  logic                        par_en,
  input  logic                        par_type,
  input  logic                        two_stop,
  output logic                        tx_out,
  output logic                        busy_flag,
  output logic                        data_lost,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_e             state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  two_stop_q;
  logic                  parity_q;

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  bit_end;
  logic                  frame_end;
  logic                  pop;
  logic                  line_bit;

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (DATA_VALID),
    .wr_data (P_DATA_from_input),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bit_end   = (baud_cnt == LAST_CNT);
  assign frame_end = bit_end && ((state == STOP2) || (state == STOP1 && !two_stop_q));
  assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

  // NOTE: line_bit gets a default first so no path through the case leaves it latched.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      START:   line_bit = 1'b0;
      DATA:    line_bit = data_q[bit_idx];
      PARITY:  line_bit = parity_q;
      default: line_bit = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_out     <= 1'b1;
      frame_done <= 1'b0;
      busy_flag  <= 1'b0;
    end else begin
      tx_out     <= line_bit;
      frame_done <= frame_end;
      busy_flag  <= (state != IDLE) || !fifo_empty;

      if (pop) begin
        data_q     <= fifo_rd_data;
        par_en_q   <= par_en;
        two_stop_q <= two_stop;
        parity_q   <= (^fifo_rd_data) ^ (par_type == PAR_ODD);
        state      <= START;
        baud_cnt   <= '0;
        bit_idx    <= '0;
      end else if (state != IDLE) begin
        if (!bit_end) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            START: begin
              state   <= DATA;
              bit_idx <= '0;
            end
            DATA: begin
              if (bit_idx == LAST_IDX) state <= par_en_q ? PARITY : STOP1;
              else                     bit_idx <= bit_idx + 1'b1;
            end
            PARITY:  state <= STOP1;
            STOP1:   state <= two_stop_q ? STOP2 : IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // A write is dropped whenever the FIFO was full before this edge, regardless of a same-cycle pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_lost <= 1'b0;
    else     data_lost <= DATA_VALID && fifo_full;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: expected line waveform is built per frame from the UART framing rules.
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int C  = 4;
  localparam int D  = 4;

  typedef bit bitq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] P_DATA_from_input;
  logic          DATA_VALID;
  logic          par_en;
  logic          par_type;
  logic          two_stop;
  logic          tx_out;
  logic          busy_flag;
  logic          data_lost;
  logic          frame_done;
  logic [$clog2(D):0] fifo_count;

  int n_vec = 0;
  int n_bad = 0;
  int lost_total = 0;
  logic [DW-1:0] wr_q[$];

  uart_tx_fifo #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .P_DATA_from_input (P_DATA_from_input),
    .DATA_VALID        (DATA_VALID),
    .par_en            (par_en),
    .par_type          (par_type),
    .two_stop          (two_stop),
    .tx_out            (tx_out),
    .busy_flag         (busy_flag),
    .data_lost         (data_lost),
    .frame_done        (frame_done),
    .fifo_count        (fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_lost === 1'b1) lost_total++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial frame: start, data LSB first, optional parity, one or two stops.
  function automatic bitq_t frame_bits(input logic [DW-1:0] d, input bit pe, input bit pt,
                                       input bit ts);
    bitq_t q;
    int ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      q.push_back(d[i]);
      ones += d[i];
    end
    if (pe) q.push_back(((ones % 2) == 1) != pt);
    q.push_back(1'b1);
    if (ts) q.push_back(1'b1);
    return q;
  endfunction

  // Called at #1 after an edge with FSM idle and FIFO empty; words come from wr_q.
  task automatic run_burst(input bit pe, input bit pt, input bit ts, input bit toggle);
    int len = wr_q.size();
    int nfr = (len < D + 1) ? len : D + 1;
    int exp_cnt = (len == 1) ? 1 : ((len - 1 < D) ? len - 1 : D);
    int lost_base = lost_total;
    par_en = pe;
    par_type = pt;
    two_stop = ts;
    fork
      begin
        for (int i = 0; i < len; i++) begin
          P_DATA_from_input = wr_q[i];
          DATA_VALID = 1'b1;
          @(posedge clk);
          #1;
        end
        DATA_VALID = 1'b0;
        @(negedge clk);
        check("count_after_writes", 32'(fifo_count), 32'(exp_cnt));
        if (toggle) begin
          @(posedge clk);
          #1;
          par_en   = ~pe;
          par_type = ~pt;
          two_stop = ~ts;
        end
      end
      begin
        repeat (3) @(posedge clk);
        for (int f = 0; f < nfr; f++) begin
          bitq_t bits = frame_bits(wr_q[f], pe, pt, ts);
          for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < C; c++) begin
              @(negedge clk);
              check("tx_out", 32'(tx_out), 32'(bits[b]));
              check("frame_done", 32'(frame_done), 32'((b == bits.size() - 1) && (c == C - 1)));
              if (c == 0) check("busy_in_frame", 32'(busy_flag), 32'd1);
            end
          end
        end
        @(negedge clk);
        check("idle_tx", 32'(tx_out), 32'd1);
        check("idle_busy", 32'(busy_flag), 32'd0);
        check("idle_count", 32'(fifo_count), 32'd0);
      end
    join
    check("lost_pulses", 32'(lost_total - lost_base), 32'(len - nfr));
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d0;
    rst = 1'b1;
    DATA_VALID = 1'b0;
    P_DATA_from_input = '0;
    par_en = 1'b0;
    par_type = 1'b0;
    two_stop = 1'b0;
    #1;
    check("rst_tx", 32'(tx_out), 32'd1);
    check("rst_busy", 32'(busy_flag), 32'd0);
    check("rst_lost", 32'(data_lost), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    #21 rst = 1'b0;
    @(posedge clk);
    #1;

    wr_q = '{8'hA5};        run_burst(1'b0, 1'b0, 1'b0, 1'b0);
    wr_q = '{8'hA5};        run_burst(1'b1, 1'b0, 1'b0, 1'b0);
    wr_q = '{8'hA5};        run_burst(1'b1, 1'b1, 1'b0, 1'b1);
    wr_q = '{8'h3C};        run_burst(1'b1, 1'b0, 1'b1, 1'b0);
    wr_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_burst(1'b0, 1'b0, 1'b0, 1'b0);
    wr_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    run_burst(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort a frame during data bit 3 with two words still queued.
    d0 = DW'($urandom_range(0, 255)) & 8'hF7;
    wr_q = '{d0, 8'h9E, 8'h47};
    for (int i = 0; i < 3; i++) begin
      P_DATA_from_input = wr_q[i];
      DATA_VALID = 1'b1;
      @(posedge clk);
      #1;
    end
    DATA_VALID = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("pre_rst_bit3", 32'(tx_out), 32'(d0[3]));
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", 32'(tx_out), 32'd1);
    check("async_rst_busy", 32'(busy_flag), 32'd0);
    check("async_rst_count", 32'(fifo_count), 32'd0);
    check("async_rst_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    check("post_rst_tx", 32'(tx_out), 32'd1);
    check("post_rst_busy", 32'(busy_flag), 32'd0);
    @(posedge clk);
    #1;
    wr_q = '{8'h55};        run_burst(1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      int len = $urandom_range(1, 7);
      bit pe = 1'($urandom_range(0, 1));
      bit pt = 1'($urandom_range(0, 1));
      bit ts = 1'($urandom_range(0, 1));
      bit tg = (len == 1) && ($urandom_range(0, 1) == 1);
      wr_q.delete();
      for (int i = 0; i < len; i++) wr_q.push_back(DW'($urandom_range(0, 255)));
      run_burst(pe, pt, ts, tg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
